// File: rtl/fetch_sequencer.sv
// MIPS IF-stage fetch controller: owns the PC, drives instruction memory, holds one IF/ID slot.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        fault,
    output logic [1:0]  state
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);

    typedef enum logic [1:0] {
        ST_RESET_WAIT = 2'b00,
        ST_RUN        = 2'b01,
        ST_HALTED     = 2'b10,
        ST_FAULT      = 2'b11
    } state_t;

    state_t      cur, nxt;
    logic [31:0] pc, pc_nxt;
    logic        slot_free, pc_bad, want, take, redirect_act;

    assign slot_free    = !if_valid || if_ready;
    assign pc_bad       = (pc >= MEM_BYTES) || (pc[1:0] != 2'b00);
    assign want         = (cur == ST_RUN) && slot_free && !redirect_valid && !halt_req;
    assign take         = want && !pc_bad;
    assign redirect_act = redirect_valid && (cur != ST_FAULT);

    assign imem_addr = pc;
    assign state     = cur;

    always_comb begin
        nxt    = cur;
        pc_nxt = pc;
        if (redirect_act) begin
            // A misaligned target still lands in pc so it is visible for debug.
            pc_nxt = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                nxt = ST_FAULT;
            end else if (halt_req) begin
                nxt = ST_HALTED;
            end else begin
                nxt = ST_RUN;
            end
        end else begin
            unique case (cur)
                ST_RESET_WAIT: nxt = ST_RUN;
                ST_RUN: begin
                    if (halt_req) begin
                        if (slot_free) begin
                            nxt = ST_HALTED;
                        end
                    end else if (want && pc_bad) begin
                        nxt = ST_FAULT;
                    end else if (take) begin
                        pc_nxt = pc + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur   <= ST_RESET_WAIT;
            pc    <= RESET_PC;
            fault <= 1'b0;
        end else begin
            cur   <= nxt;
            pc    <= pc_nxt;
            fault <= fault | (nxt == ST_FAULT);
        end
    end

    // IF/ID slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid    <= 1'b0;
            if_instr    <= 32'd0;
            if_pc       <= 32'd0;
            if_pc_plus4 <= 32'd0;
        end else if (take) begin
            if_valid    <= 1'b1;
            if_instr    <= imem_rdata;
            if_pc       <= pc;
            if_pc_plus4 <= pc + 32'd4;
        end else if (redirect_act || if_ready) begin
            if_valid    <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
            perf_flush   <= 32'd0;
        end else if (cur != ST_FAULT) begin
            if (take) begin
                perf_fetched <= sat_inc(perf_fetched);
            end
            if (if_valid && !if_ready) begin
                perf_stall <= sat_inc(perf_stall);
            end
            if (redirect_act && if_valid) begin
                perf_flush <= sat_inc(perf_flush);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed test-plan scenarios followed by randomized traffic,
// checked against a rule-level reference model of the fetch stream.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr, if_pc, if_pc_plus4;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt_req = 1'b0;
    logic        fault;
    logic [1:0]  state;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall, perf_flush;
    int unsigned p_fetch = 0, p_stall = 0, p_flush = 0;
`endif

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    assign imem_rdata = (imem_addr < 32'd1024) ? mem[imem_addr[9:2]] : 32'd0;

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .fault(fault), .state(state)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } slot_t;

    // Reference model: 0 reset-wait, 1 run, 2 halted, 3 fault
    slot_t       q[$];
    int          m_state = 0;
    logic [31:0] m_pc = 32'd0;
    bit          m_valid = 1'b0;
    bit          m_consumed, m_free;
    slot_t       s_new;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_state = 0;
                m_pc    = 32'd0;
                m_valid = 1'b0;
                q.delete();
`ifdef FETCH_PERF_EN
                p_fetch = 0; p_stall = 0; p_flush = 0;
`endif
            end else begin
                m_consumed = m_valid && if_ready;
                m_free     = !m_valid || if_ready;
`ifdef FETCH_PERF_EN
                if (m_state != 3) begin
                    if (m_valid && !if_ready) p_stall++;
                    if (redirect_valid && m_valid) p_flush++;
                end
`endif
                if (m_state == 3) begin
                    if (m_consumed) m_valid = 1'b0;
                end else if (redirect_valid) begin
                    m_valid = 1'b0;
                    q.delete();
                    m_pc = redirect_pc;
                    if (redirect_pc[1:0] != 2'b00) m_state = 3;
                    else if (halt_req)             m_state = 2;
                    else                           m_state = 1;
                end else if (m_state == 1 && !halt_req && m_free) begin
                    if (m_pc >= 32'd1024 || m_pc[1:0] != 2'b00) begin
                        m_valid = 1'b0;
                        m_state = 3;
                    end else begin
                        s_new.pc    = m_pc;
                        s_new.instr = mem[m_pc[9:2]];
                        q.push_back(s_new);
                        m_valid = 1'b1;
                        m_pc    = m_pc + 32'd4;
`ifdef FETCH_PERF_EN
                        p_fetch++;
`endif
                    end
                end else begin
                    if (m_consumed) m_valid = 1'b0;
                    if (m_state == 0) m_state = 1;
                    else if (m_state == 1 && halt_req && m_free) m_state = 2;
                end
            end
        end
    end

    // Monitor: compares on the falling edge, pops the scoreboard on each handshake
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_state", {30'd0, state}, 32'd0);
                check("rst_valid", {31'd0, if_valid}, 32'd0);
                check("rst_fault", {31'd0, fault}, 32'd0);
                check("rst_addr", imem_addr, 32'd0);
                check("rst_instr", if_instr, 32'd0);
                check("rst_pc", if_pc, 32'd0);
                check("rst_pc4", if_pc_plus4, 32'd0);
            end else begin
                check("imem_addr", imem_addr, m_pc);
                check("state", {30'd0, state}, 32'(m_state));
                check("fault", {31'd0, fault}, (m_state == 3) ? 32'd1 : 32'd0);
                check("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
                if (if_valid) begin
                    if (q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL slot_unexpected: if_valid=1 with if_pc=%h, expected no instruction (t=%0t)",
                                 if_pc, $time);
                    end else begin
                        check("if_pc", if_pc, q[0].pc);
                        check("if_instr", if_instr, q[0].instr);
                        check("if_pc_plus4", if_pc_plus4, q[0].pc + 32'd4);
                        if (if_ready) void'(q.pop_front());
                    end
                end
`ifdef FETCH_PERF_EN
                check("perf_fetched", perf_fetched, p_fetch);
                check("perf_stall", perf_stall, p_stall);
                check("perf_flush", perf_flush, p_flush);
`endif
            end
        end
    end

    task automatic cyc(input bit rdy, input bit rv, input logic [31:0] rp, input bit h);
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rp;
        halt_req       = h;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(bit'($urandom_range(0, 1)), 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        rst_n = 1'b1;
    endtask

    logic [31:0] rp;
    bit          h_rand;
    int          fault_cycles;
    int          sel;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        #1;
        do_reset();

        // Straight-line run, then a 3-cycle stall and release
        repeat (4) cyc(1'b1, 1'b0, 32'd0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 32'd0, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 32'd0, 1'b0);
        // Redirect to 0x40 with a valid slot
        cyc(1'b1, 1'b1, 32'h40, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 32'd0, 1'b0);
        // Halt with a full stalled slot, drain, then resume by redirect
        repeat (3) cyc(1'b0, 1'b0, 32'd0, 1'b1);
        repeat (2) cyc(1'b1, 1'b0, 32'd0, 1'b1);
        cyc(1'b1, 1'b1, 32'h20, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 32'd0, 1'b0);
        // Run off the end of memory
        cyc(1'b1, 1'b1, 32'h3F4, 1'b0);
        repeat (7) cyc(1'b1, 1'b0, 32'd0, 1'b0);
        do_reset();
        // Misaligned redirect
        repeat (3) cyc(1'b1, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 32'h22, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 32'h40, 1'b0);
        do_reset();

        h_rand = 1'b0;
        fault_cycles = 0;
        for (int n = 0; n < 4000; n++) begin
            fault_cycles = (m_state == 3) ? fault_cycles + 1 : 0;
            if (fault_cycles > 4 || $urandom_range(0, 399) == 0) begin
                do_reset();
                fault_cycles = 0;
            end
            if ($urandom_range(0, 29) == 0) h_rand = !h_rand;
            sel = $urandom_range(0, 15);
            rp  = 32'($urandom_range(0, 1023));
            if (sel == 0) begin
                if (rp[1:0] == 2'b00) rp[0] = 1'b1;
            end else if (sel < 4) begin
                rp = 32'h3F0 + 32'($urandom_range(0, 3)) * 32'd4;
            end else begin
                rp[1:0] = 2'b00;
            end
            cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0), rp, h_rand);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the MIPS pipeline IF stage.
- Owns the PC and drives the byte address into the combinational instruction memory (256 x 32, word index = addr>>2, reads 0 at addr >= 1024).
- Holds one registered IF/ID slot with a valid/ready handshake toward decode.
- Handles branch/jump redirects, halt requests and out-of-range or misaligned fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- MEM_BYTES, 1024, size of instruction memory in bytes; fetches at PC >= MEM_BYTES fault.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_addr  output  32  byte address to instruction memory; combinational copy of pc.
- imem_rdata  input  32  instruction word returned combinationally in the same cycle.
- if_valid  output  1  IF/ID slot holds a valid instruction.
- if_ready  input  1  decode accepts the slot this cycle.
- if_instr  output  32  registered instruction.
- if_pc  output  32  byte address of if_instr.
- if_pc_plus4  output  32  if_pc + 4.
- redirect_valid  input  1  branch/jump taken; flushes the slot.
- redirect_pc  input  32  redirect target.
- halt_req  input  1  stop fetching after draining the slot.
- fault  output  1  sticky fault flag.
- state  output  2  00 RESET_WAIT, 01 RUN, 10 HALTED, 11 FAULT.

Behaviour:
- Reset values (async, rst_n low):
  - pc = RESET_PC; if_valid = 0; if_instr = 0; if_pc = 0; if_pc_plus4 = 0.
  - fault = 0; state = RESET_WAIT.
- RESET_WAIT: lasts exactly one clk after rst_n deasserts, with no fetch, then moves to RUN. This gives the memory load time.
- Slot update condition: take = (state == RUN) && (!if_valid || if_ready) && !redirect_valid && !halt_req.
- On take:
  - if_instr <= imem_rdata; if_pc <= pc; if_pc_plus4 <= pc + 4.
  - if_valid <= 1; pc <= pc + 4 (32-bit wrap, no carry-out).
- Throughput and latency:
  - One instruction per cycle at full throughput.
  - Fetch-to-slot latency is 1 clk.
- Stall: if_valid && !if_ready means slot contents, pc and imem_addr are all held stable.
- Consume without refill: if_ready while take is false clears if_valid.
- Redirect (highest priority, any state except FAULT):
  - if_valid <= 0; pc <= redirect_pc.
  - In the same cycle, the slot is neither loaded nor checked.
  - The first instruction from the target appears in the slot 1 clk later. The redirect bubble is 1 cycle.
  - redirect_pc[1:0] != 0 goes to FAULT; fault <= 1; pc still loads the target for debug.
  - Redirect in HALTED loads pc and returns to RUN.
- Halt:
  - halt_req in RUN stops new takes.
  - The current slot stays valid until consumed, then state moves to HALTED.
  - If the slot is empty, HALTED is entered on the next edge.
  - Redirect and halt_req in the same cycle: the redirect is applied, then state becomes HALTED.
- Range fault: in RUN, pc >= MEM_BYTES or pc[1:0] != 0 at a potential take means:
  - No take occurs.
  - The existing slot drains normally.
  - state moves to FAULT and fault is set.
- FAULT is sticky. No fetches, no redirects, slot drains only. Exit is only by rst_n.
- Reset mid-stall or mid-redirect: all registers return to reset values immediately, asynchronously.
- imem_addr always equals pc, including in HALTED and FAULT.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, three extra outputs are added:
  - perf_fetched (32): count of takes.
  - perf_stall (32): count of cycles with if_valid && !if_ready.
  - perf_flush (32): count of redirects that discarded a valid slot.
- Counter behaviour: all reset to 0; each saturates at 32'hFFFF_FFFF; all freeze in FAULT.
- When not defined, these ports and counters do not exist and the behaviour is otherwise identical.

Test Plan:
- Straight-line run: memory holds words A0..A7 at 0..28, if_ready=1 -> after reset, RESET_WAIT for 1 clk, then if_pc = 0,4,8,... on consecutive cycles, if_instr = A0,A1,..., no bubbles.
- Stall: hold if_ready=0 for 3 cycles while slot holds pc=8 -> if_instr, if_pc = 8 and imem_addr = 12 all stay constant; on release, pc=12 enters the slot next cycle.
- Redirect: redirect_valid with redirect_pc=0x40 while slot holds pc=0x10 -> if_valid=0 for 1 cycle, then if_pc=0x40 and if_pc_plus4=0x44.
- Halt with full slot, if_ready=0: assert halt_req -> state stays RUN, then goes HALTED on the cycle after the slot is consumed; a later redirect to 0x20 resumes RUN with if_pc=0x20.
- Faults:
  - Redirect to 0x3FC, run on: 0x3FC is fetched, then pc=0x400 gives state=11, fault=1 and no further if_valid.
  - A separate run with redirect_pc=0x22 faults immediately.
  - Asserting rst_n low clears both cases.
- FETCH_PERF_EN: 5 takes, 2 stall cycles and 1 flushing redirect give perf_fetched=5, perf_stall=2, perf_flush=1.
